serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  operation select, latched with start: 0 = a+b, 1 = a-b.
REQ-006 a  input  WIDTH  operand A, latched with start.
REQ-007 b  input  WIDTH  operand B, latched with start.
REQ-008 busy  output  1  high while state is RUN or DONE.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  result; holds until the next accepted start.
REQ-011 cout  output  1  final carry; for sub, 1 = no borrow.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE, with a single registered state variable.
REQ-013 In IDLE with start=1 at edge T, the block SHALL latch a, b and sub, clear the bit counter, and set the carry register to sub.
REQ-014 At the same edge, sum and cout SHALL clear to 0, and the state SHALL go to RUN at T+1.
REQ-015 In each RUN cycle, the block SHALL add one bit pair LSB-first through the 1-bit full-adder datapath.
REQ-016 The operand used for each bit SHALL be b XOR sub.
REQ-017 Each RUN cycle SHALL shift the resulting sum bit into sum MSB-first (right shift), update the carry register, and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles (T+1..T+WIDTH); when counter = WIDTH-1, the next state SHALL be DONE.
REQ-019 In DONE (T+WIDTH+1), done SHALL be 1 and cout SHALL equal the carry register; the next state SHALL be IDLE unconditionally.
REQ-020 Latency from accepted start to done SHALL be WIDTH+1 cycles; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; operand changes after acceptance SHALL have no effect.
REQ-022 done SHALL never be high for more than one consecutive cycle.
REQ-023 sum and cout SHALL be stable from the done cycle until the next accepted start.
REQ-024 The result SHALL wrap modulo 2^WIDTH; overflow is reported only through cout.
REQ-025 The counter width SHALL be $clog2(WIDTH); the counter SHALL not wrap during RUN.

Reset
REQ-026 When rst=1, on the next edge: state = IDLE, busy = 0, done = 0, sum = 0, cout = 0, counter = 0, carry = 0, operand registers = 0.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-028 rst SHALL take priority over start in the same cycle.
REQ-029 The first start SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-030 A shared package/header serial_adder_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH.
REQ-031 Encoding 2'd3 SHALL recover to IDLE.
REQ-032 One combinational sub-module, serial_full_adder, SHALL implement sum = x^y^cin and cout = (x&y)|(cin&(x^y)) as two cascaded half-adder stages; it SHALL be instantiated once.
REQ-033 All other logic (FSM, counter, shift registers) SHALL reside in serial_adder_ctrl, with no latches.

Verification (WIDTH=8)
REQ-034 start, sub=0, a=0x5A, b=0x3C at T -> busy=1 T+1..T+9, done=1 only at T+9, sum=0x96, cout=0.
REQ-035 sub=0, a=0xFF, b=0x01 -> sum=0x00, cout=1 at done.
REQ-036 sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1; then sub=1, a=0x00, b=0x01 -> sum=0xFF, cout=0.
REQ-037 start re-pulsed at T+3 with a=0x01, b=0x01 during an active 0x5A+0x3C -> ignored; result 0x96; only one done pulse.
REQ-038 rst=1 at T+4 of a run -> at T+5: busy=0, sum=0, cout=0, no done pulse; start at T+6 completes normally at T+15.
REQ-039 Back-to-back starts held high continuously -> done every 10 cycles; scoreboard matches (a ± b) mod 256 for 1000 random vectors.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared state encodings and default operand width for the
//               bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

endpackage

`default_nettype wire

// File: rtl/serial_full_adder.sv
// ============================================================================
// Module      : serial_full_adder
// Description : 1-bit full adder built from two cascaded half-adder stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p1;
    logic w_g1;
    logic w_g2;

    assign w_p1 = x ^ y;
    assign w_g1 = x & y;
    assign sum  = w_p1 ^ cin;
    assign w_g2 = cin & w_p1;
    assign cout = w_g1 | w_g2;

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial add/subtract controller; one bit pair per RUN cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_y;
    logic               w_bit;
    logic               w_carry;

    // Subtraction is a + ~b + 1: invert b per bit, carry seeded with sub.
    assign w_y = r_b[0] ^ r_sub;

    serial_full_adder u_fa (
        .x    (r_a[0]),
        .y    (w_y),
        .cin  (r_carry),
        .sum  (w_bit),
        .cout (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sub   <= sub;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry;
                    // Counter stops at its last value rather than wrapping.
                    if (r_cnt == c_cnt_last) begin
                        r_cout  <= w_carry;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy = (r_state == c_st_run) || (r_state == c_st_done);
    assign done = (r_state == c_st_done);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire
